// File: rtl/beta_alu_vsn2.sv
// Beta ALU: single-cycle arithmetic/logic/compare/shift ops plus iterative
// shift-add multiply and signed restoring divide behind a busy handshake.
module beta_alu_vsn2 #(
  parameter int ALU_DATA_WIDTH = 32,
  parameter int ALU_OP_WIDTH   = 4
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      ALU_EN,
  input  logic [ALU_OP_WIDTH-1:0]   ALU_OP,
  input  logic [ALU_DATA_WIDTH-1:0] DATA_X,
  input  logic [ALU_DATA_WIDTH-1:0] DATA_Y,
  output logic [ALU_DATA_WIDTH-1:0] ALU_OUT,
  output logic                      ALU_VALID,
  output logic                      ALU_BUSY,
  output logic                      DIV_ZERO
);

  localparam int W  = ALU_DATA_WIDTH;
  localparam int SW = $clog2(W);
  localparam logic [SW-1:0] LAST_STEP = SW'(W - 1);

  localparam logic [ALU_OP_WIDTH-1:0] OP_ADD   = ALU_OP_WIDTH'(4'h0);
  localparam logic [ALU_OP_WIDTH-1:0] OP_SUB   = ALU_OP_WIDTH'(4'h1);
  localparam logic [ALU_OP_WIDTH-1:0] OP_MUL   = ALU_OP_WIDTH'(4'h2);
  localparam logic [ALU_OP_WIDTH-1:0] OP_DIV   = ALU_OP_WIDTH'(4'h3);
  localparam logic [ALU_OP_WIDTH-1:0] OP_CMPEQ = ALU_OP_WIDTH'(4'h4);
  localparam logic [ALU_OP_WIDTH-1:0] OP_CMPLT = ALU_OP_WIDTH'(4'h5);
  localparam logic [ALU_OP_WIDTH-1:0] OP_CMPLE = ALU_OP_WIDTH'(4'h6);
  localparam logic [ALU_OP_WIDTH-1:0] OP_AND   = ALU_OP_WIDTH'(4'h8);
  localparam logic [ALU_OP_WIDTH-1:0] OP_OR    = ALU_OP_WIDTH'(4'h9);
  localparam logic [ALU_OP_WIDTH-1:0] OP_XOR   = ALU_OP_WIDTH'(4'hA);
  localparam logic [ALU_OP_WIDTH-1:0] OP_SHL   = ALU_OP_WIDTH'(4'hC);
  localparam logic [ALU_OP_WIDTH-1:0] OP_SHR   = ALU_OP_WIDTH'(4'hD);
  localparam logic [ALU_OP_WIDTH-1:0] OP_SRA   = ALU_OP_WIDTH'(4'hE);

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL_ITER,
    S_DIV_ITER,
    S_DIV_FIX
  } state_t;

  state_t          state_q, state_d;
  logic [SW-1:0]   cnt_q, cnt_d;
  logic [W-1:0]    out_q, out_d;
  logic            valid_q, valid_d;
  logic            dz_q, dz_d;
  logic [W-1:0]    acc_q, acc_d;   // multiply accumulator
  logic [W:0]      rem_q, rem_d;   // divide partial remainder
  logic [W-1:0]    a_q, a_d;       // multiplicand / dividend-then-quotient
  logic [W-1:0]    b_q, b_d;       // multiplier / divisor magnitude
  logic            neg_q, neg_d;

  logic [SW-1:0]   shamt;
  logic [W-1:0]    mul_sum;
  logic [W:0]      rem_sh;
  logic [W:0]      trial;
  logic            trial_ok;

  assign shamt    = DATA_Y[SW-1:0];
  assign mul_sum  = acc_q + (b_q[0] ? a_q : '0);
  assign rem_sh   = {rem_q[W-1:0], a_q[W-1]};
  assign trial    = rem_sh - {1'b0, b_q};
  assign trial_ok = ~trial[W];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    valid_d = 1'b0;
    dz_d    = dz_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    a_d     = a_q;
    b_d     = b_q;
    neg_d   = neg_q;

    case (state_q)
      S_IDLE: begin
        if (ALU_EN) begin
          valid_d = 1'b1;
          dz_d    = 1'b0;
          case (ALU_OP)
            OP_ADD:   out_d = DATA_X + DATA_Y;
            OP_SUB:   out_d = DATA_X - DATA_Y;
            OP_CMPEQ: out_d = {{(W-1){1'b0}}, DATA_X == DATA_Y};
            OP_CMPLT: out_d = {{(W-1){1'b0}}, $signed(DATA_X) <  $signed(DATA_Y)};
            OP_CMPLE: out_d = {{(W-1){1'b0}}, $signed(DATA_X) <= $signed(DATA_Y)};
            OP_AND:   out_d = DATA_X & DATA_Y;
            OP_OR:    out_d = DATA_X | DATA_Y;
            OP_XOR:   out_d = DATA_X ^ DATA_Y;
            OP_SHL:   out_d = DATA_X << shamt;
            OP_SHR:   out_d = DATA_X >> shamt;
            OP_SRA:   out_d = W'($signed(DATA_X) >>> shamt);
            OP_MUL: begin
              valid_d = 1'b0;
              dz_d    = dz_q;
              a_d     = DATA_X;
              b_d     = DATA_Y;
              acc_d   = '0;
              cnt_d   = '0;
              state_d = S_MUL_ITER;
            end
            OP_DIV: begin
              if (DATA_Y == '0) begin
                out_d = '1;
                dz_d  = 1'b1;
              end else begin
                // Divide magnitudes; sign applied in the fix cycle, which also
                // makes MIN / -1 wrap back to MIN.
                valid_d = 1'b0;
                dz_d    = dz_q;
                a_d     = DATA_X[W-1] ? -DATA_X : DATA_X;
                b_d     = DATA_Y[W-1] ? -DATA_Y : DATA_Y;
                neg_d   = DATA_X[W-1] ^ DATA_Y[W-1];
                rem_d   = '0;
                cnt_d   = '0;
                state_d = S_DIV_ITER;
              end
            end
            default:  out_d = '0;
          endcase
        end
      end

      S_MUL_ITER: begin
        acc_d = mul_sum;
        a_d   = a_q << 1;
        b_d   = b_q >> 1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_STEP) begin
          out_d   = mul_sum;
          valid_d = 1'b1;
          dz_d    = 1'b0;
          cnt_d   = '0;
          state_d = S_IDLE;
        end
      end

      S_DIV_ITER: begin
        rem_d = trial_ok ? trial : rem_sh;
        a_d   = {a_q[W-2:0], trial_ok};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LAST_STEP) begin
          cnt_d   = '0;
          state_d = S_DIV_FIX;
        end
      end

      S_DIV_FIX: begin
        out_d   = neg_q ? -a_q : a_q;
        valid_d = 1'b1;
        dz_d    = 1'b0;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
      dz_q    <= 1'b0;
      acc_q   <= '0;
      rem_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      neg_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      dz_q    <= dz_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
      a_q     <= a_d;
      b_q     <= b_d;
      neg_q   <= neg_d;
    end
  end

  assign ALU_OUT   = out_q;
  assign ALU_VALID = valid_q;
  assign ALU_BUSY  = (state_q != S_IDLE);
  assign DIV_ZERO  = dz_q;

endmodule

// File: tb/tb_beta_alu_vsn2.sv
// Directed bench for beta_alu_vsn2: expected results queued at issue time and
// checked by a monitor whenever ALU_VALID is seen, including arrival cycle.
module tb_beta_alu_vsn2;

  logic        CLK = 1'b0;
  logic        RST;
  logic        ALU_EN;
  logic [3:0]  ALU_OP;
  logic [31:0] DATA_X;
  logic [31:0] DATA_Y;
  logic [31:0] ALU_OUT;
  logic        ALU_VALID;
  logic        ALU_BUSY;
  logic        DIV_ZERO;

  beta_alu_vsn2 #(.ALU_DATA_WIDTH(32), .ALU_OP_WIDTH(4)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .ALU_EN   (ALU_EN),
    .ALU_OP   (ALU_OP),
    .DATA_X   (DATA_X),
    .DATA_Y   (DATA_Y),
    .ALU_OUT  (ALU_OUT),
    .ALU_VALID(ALU_VALID),
    .ALU_BUSY (ALU_BUSY),
    .DIV_ZERO (DIV_ZERO)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] out;
    logic        dz;
    int          due;
    string       tag;
  } exp_t;

  exp_t q[$];
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Scoreboard consumer: every valid pulse must match the oldest queued entry.
  always @(negedge CLK) begin
    if (ALU_VALID === 1'b1) begin
      total++;
      assert (q.size() > 0) else begin
        bad++;
        $error("FAIL spurious_valid observed=valid(out=%h) expected=no valid", ALU_OUT);
      end
      if (q.size() > 0) begin
        exp_t e;
        e = q.pop_front();
        chk({e.tag, "_out"}, ALU_OUT, e.out);
        chk({e.tag, "_dz"}, 32'(DIV_ZERO), 32'(e.dz));
        chk({e.tag, "_cycle"}, 32'(cyc), 32'(e.due));
      end
    end
  end

  // Drives one request for one edge; lat is the number of cycles until the
  // valid pulse (1 = visible in the cycle right after acceptance).
  task automatic issue(input string tag, input logic [3:0] op, input logic [31:0] x,
                       input logic [31:0] y, input logic [31:0] eo, input logic edz,
                       input int lat, input bit expect_result);
    exp_t e;
    ALU_OP = op;
    DATA_X = x;
    DATA_Y = y;
    ALU_EN = 1'b1;
    if (expect_result) begin
      e.out = eo; e.dz = edz; e.due = cyc + lat; e.tag = tag;
      q.push_back(e);
    end
    @(posedge CLK);
    #1;
    ALU_EN = 1'b0;
    ALU_OP = 4'($urandom_range(0, 15));
    DATA_X = $urandom;
    DATA_Y = $urandom;
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (q.size() != 0 && n < 100) begin
      @(negedge CLK);
      #1;
      n++;
    end
    chk({tag, "_drain_pending"}, 32'(q.size()), 32'd0);
  endtask

  initial begin
    int busy_cnt;
    RST = 1'b1; ALU_EN = 1'b0; ALU_OP = '0; DATA_X = '0; DATA_Y = '0;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_out",   ALU_OUT, 32'h0);
    chk("rst_valid", 32'(ALU_VALID), 32'd0);
    chk("rst_busy",  32'(ALU_BUSY), 32'd0);
    chk("rst_dz",    32'(DIV_ZERO), 32'd0);
    RST = 1'b0;
    @(posedge CLK); #1;

    issue("add_wrap", 4'h0, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b0, 1, 1'b1);
    chk("add_busy", 32'(ALU_BUSY), 32'd0);
    // back-to-back single-cycle ops
    issue("sub",      4'h1, 32'd3, 32'd5, 32'hFFFF_FFFE, 1'b0, 1, 1'b1);
    issue("cmplt_n",  4'h5, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 1, 1'b1);
    issue("cmple_eq", 4'h6, 32'd5, 32'd5, 32'd1, 1'b0, 1, 1'b1);
    issue("cmplt_eq", 4'h5, 32'd5, 32'd5, 32'd0, 1'b0, 1, 1'b1);
    issue("cmpeq_ne", 4'h4, 32'd7, 32'd8, 32'd0, 1'b0, 1, 1'b1);
    issue("cmpeq_eq", 4'h4, 32'd9, 32'd9, 32'd1, 1'b0, 1, 1'b1);
    issue("and",      4'h8, 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'h00F0_000F, 1'b0, 1, 1'b1);
    issue("or",       4'h9, 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'hFFF0_0FFF, 1'b0, 1, 1'b1);
    issue("xor",      4'hA, 32'hF0F0_00FF, 32'h0FF0_0F0F, 32'hFF00_0FF0, 1'b0, 1, 1'b1);
    issue("sra",      4'hE, 32'h8000_0000, 32'd4, 32'hF800_0000, 1'b0, 1, 1'b1);
    issue("shl_wrap", 4'hC, 32'd1, 32'd33, 32'h0000_0002, 1'b0, 1, 1'b1);
    issue("shr_31",   4'hD, 32'h8000_0000, 32'd31, 32'h0000_0001, 1'b0, 1, 1'b1);
    issue("shr_hiy",  4'hD, 32'h8000_0000, 32'h25, 32'h0400_0000, 1'b0, 1, 1'b1);
    issue("nop",      4'h7, 32'h1234_5678, 32'h9, 32'h0, 1'b0, 1, 1'b1);
    drain("single");

    // MUL with mid-busy ADD (ignored) and valid-cycle ADD (accepted)
    issue("mul_neg", 4'h2, 32'hFFFF_FFFF, 32'd3, 32'hFFFF_FFFD, 1'b0, 33, 1'b1);
    busy_cnt = 0;
    for (int i = 0; i < 200; i++) begin
      if (ALU_BUSY !== 1'b1) break;
      busy_cnt++;
      if (busy_cnt == 5) begin
        ALU_EN = 1'b1; ALU_OP = 4'h0; DATA_X = 32'h1111_0000; DATA_Y = 32'h0000_2222;
      end else begin
        ALU_EN = 1'b0;
      end
      @(posedge CLK); #1;
    end
    chk("mul_busy_cycles", 32'(busy_cnt), 32'd32);
    issue("add_b2b", 4'h0, 32'd40, 32'd2, 32'd42, 1'b0, 1, 1'b1);
    drain("mul");
    repeat (3) @(posedge CLK);
    #1;
    chk("out_hold", ALU_OUT, 32'd42);

    issue("mul_pos", 4'h2, 32'h0001_2345, 32'h100, 32'h0123_4500, 1'b0, 33, 1'b1);
    drain("mul2");

    issue("div_neg", 4'h3, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0, 34, 1'b1);
    drain("div1");
    issue("div_zero", 4'h3, 32'd5, 32'd0, 32'hFFFF_FFFF, 1'b1, 1, 1'b1);
    drain("div2");
    @(posedge CLK); #1;
    chk("dz_hold", 32'(DIV_ZERO), 32'd1);
    issue("div_min", 4'h3, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 34, 1'b1);
    drain("div3");
    issue("div_trunc", 4'h3, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 1'b0, 34, 1'b1);
    drain("div4");
    issue("div_zero2", 4'h3, 32'h7, 32'd0, 32'hFFFF_FFFF, 1'b1, 1, 1'b1);
    drain("div5");

    // reset abandons a DIV in flight
    issue("div_abort", 4'h3, 32'd1000, 32'd3, 32'd0, 1'b0, 34, 1'b0);
    repeat (9) @(posedge CLK);
    #1;
    chk("abort_busy_before", 32'(ALU_BUSY), 32'd1);
    RST = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0;
    chk("abort_out",   ALU_OUT, 32'h0);
    chk("abort_valid", 32'(ALU_VALID), 32'd0);
    chk("abort_busy",  32'(ALU_BUSY), 32'd0);
    chk("abort_dz",    32'(DIV_ZERO), 32'd0);
    repeat (40) @(posedge CLK);
    #1;
    chk("abort_out_later", ALU_OUT, 32'h0);
    chk("final_queue", 32'(q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $error("FAIL watchdog observed=timeout expected=completion");
    bad++;
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
